// File: rtl/pixel_arbiter_pkg.sv
// rtl/pixel_arbiter_pkg.sv - shared screen, source and state constants for the draw pipeline
package pixel_arbiter_pkg;

  // Playfield geometry shared with the draw FSMs
  localparam int GRID_CELL = 4;
  localparam int BRICK_W   = 10;
  localparam int BRICK_H   = 5;
  localparam int PLAT_W    = 20;

  // Visible VGA area; anything at or beyond these is clipped
  localparam int SCREEN_W  = 160;
  localparam int SCREEN_H  = 120;

  localparam int COORD_W   = 10;
  localparam int COLOUR_W  = 3;

  // Draw source indices into the arbiter request vector
  localparam int SRC_PLAT  = 0;
  localparam int SRC_BALL  = 1;
  localparam int SRC_BRICK = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_e;

endpackage

// File: rtl/pixel_arbiter_rr_picker.sv
// rtl/pixel_arbiter_rr_picker.sv - combinational round-robin pick starting after the last served source
module rr_picker #(
  parameter int N_SRC = 3,
  parameter int IDX_W = 2
) (
  input  logic [N_SRC-1:0] valid_i,
  input  logic [IDX_W-1:0] last_served_i,
  output logic [IDX_W-1:0] grant_o,
  output logic             any_valid_o
);

  // Scan farthest-to-nearest so the nearest valid index after last_served overwrites the rest
  always_comb begin : scan
    int idx;
    grant_o     = '0;
    any_valid_o = 1'b0;
    idx         = 0;
    for (int k = N_SRC; k >= 1; k--) begin
      idx = (int'(last_served_i) + k) % N_SRC;
      if (valid_i[IDX_W'(idx)]) begin
        grant_o     = IDX_W'(idx);
        any_valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pixel_arbiter.sv
// rtl/pixel_arbiter.sv - burst-locked round-robin merge of draw-FSM pixel streams into the VGA write port
module pixel_arbiter #(
  parameter int N_SRC    = 3,
  parameter int SCREEN_W = pixel_arbiter_pkg::SCREEN_W,
  parameter int SCREEN_H = pixel_arbiter_pkg::SCREEN_H,
  parameter int TIMEOUT  = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N_SRC-1:0]     src_valid,
  input  logic [N_SRC-1:0]     src_last,
  input  logic [10*N_SRC-1:0]  src_x,
  input  logic [10*N_SRC-1:0]  src_y,
  input  logic [3*N_SRC-1:0]   src_colour,
  output logic [N_SRC-1:0]     src_ready,
  output logic [9:0]           vga_x,
  output logic [9:0]           vga_y,
  output logic [2:0]           vga_colour,
  output logic                 vga_plot,
  output logic                 busy
);
  import pixel_arbiter_pkg::*;

  localparam int IDX_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;
  localparam int WD_W  = $clog2(TIMEOUT);

  arb_state_e       state_q;
  logic [IDX_W-1:0] grant_q;
  logic [IDX_W-1:0] last_q;
  logic [WD_W-1:0]  wd_q;
  logic [9:0]       x_q;
  logic [9:0]       y_q;
  logic [2:0]       col_q;
  logic             plot_q;

  logic [IDX_W-1:0] pick;
  logic             any_valid;
  logic [9:0]       x_arr [N_SRC];
  logic [9:0]       y_arr [N_SRC];
  logic [2:0]       c_arr [N_SRC];
  logic [9:0]       sel_x;
  logic [9:0]       sel_y;
  logic [2:0]       sel_c;
  logic             sel_last;
  logic             accept;
  logic             plot_d;

  rr_picker #(
    .N_SRC (N_SRC),
    .IDX_W (IDX_W)
  ) u_rr (
    .valid_i       (src_valid),
    .last_served_i (last_q),
    .grant_o       (pick),
    .any_valid_o   (any_valid)
  );

  // Unpack the per-source buses and select the granted source's pixel
  always_comb begin
    for (int i = 0; i < N_SRC; i++) begin
      x_arr[i] = src_x[10*i +: 10];
      y_arr[i] = src_y[10*i +: 10];
      c_arr[i] = src_colour[3*i +: 3];
    end
    sel_x    = x_arr[grant_q];
    sel_y    = y_arr[grant_q];
    sel_c    = c_arr[grant_q];
    sel_last = src_last[grant_q];
    accept   = (state_q == BURST) && src_valid[grant_q];
    plot_d   = accept && (sel_x < 10'(SCREEN_W)) && (sel_y < 10'(SCREEN_H));
  end

  // Grant is one-hot on the locked source only while a burst is open
  always_comb begin
    src_ready = '0;
    if (state_q == BURST) src_ready[grant_q] = 1'b1;
  end

  // Arbitration FSM, watchdog and registered VGA write port
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= IDX_W'(N_SRC - 1);
      wd_q    <= '0;
      x_q     <= '0;
      y_q     <= '0;
      col_q   <= '0;
      plot_q  <= 1'b0;
    end else begin
      plot_q <= plot_d;
      case (state_q)
        IDLE: begin
          wd_q <= '0;
          if (any_valid) begin
            grant_q <= pick;
            state_q <= BURST;
          end
        end
        BURST: begin
          if (accept) begin
            x_q   <= sel_x;
            y_q   <= sel_y;
            col_q <= sel_c;
            wd_q  <= '0;
            if (sel_last) begin
              last_q  <= grant_q;
              state_q <= IDLE;
            end
          end else if (wd_q == WD_W'(TIMEOUT - 1)) begin
            // Stalled source: give up the lock so others are not starved
            last_q  <= grant_q;
            state_q <= IDLE;
            wd_q    <= '0;
          end else begin
            wd_q <= wd_q + WD_W'(1);
          end
        end
      endcase
    end
  end

  assign vga_x      = x_q;
  assign vga_y      = y_q;
  assign vga_colour = col_q;
  assign vga_plot   = plot_q;
  assign busy       = (state_q == BURST);

endmodule

// File: tb/tb_pixel_arbiter.sv
// tb/tb_pixel_arbiter.sv - randomized and directed checks of pixel_arbiter against a transaction model
module tb_pixel_arbiter;
  import pixel_arbiter_pkg::*;

  localparam int N  = 3;
  localparam int TO = 64;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    src_valid, src_last, src_ready;
  logic [10*N-1:0] src_x, src_y;
  logic [3*N-1:0]  src_colour;
  logic [9:0]      vga_x, vga_y;
  logic [2:0]      vga_colour;
  logic            vga_plot, busy;

  pixel_arbiter #(.N_SRC(N), .SCREEN_W(160), .SCREEN_H(120), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .src_valid(src_valid), .src_last(src_last),
    .src_x(src_x), .src_y(src_y), .src_colour(src_colour), .src_ready(src_ready),
    .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour), .vga_plot(vga_plot), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // Per-source pixel FIFOs: word = {last, colour, y, x}
  logic [23:0] mem [N][1024];
  int  head [N];
  int  tail [N];
  bit  present [N];
  int  bubble_pct;

  // Model: who owns the port (-1 = nobody), who was served last, idle cycles in the burst
  int          m_owner, m_last, m_idle;
  bit          m_plot;
  logic [9:0]  m_x, m_y;
  logic [2:0]  m_c;

  bit          chk_en;
  bit          prev_busy;
  int          cyc;
  logic [23:0] plot_log [4096];
  int          plot_cyc [4096];
  int          plot_n;
  int          grant_log [512];
  int          grant_n;
  int          pb, gb;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int s, input int x, input int y, input int c, input bit last);
    mem[s][tail[s] % 1024] = {last, 3'(c), 10'(y), 10'(x)};
    tail[s]++;
  endtask

  task automatic compare();
    logic [N-1:0] er;
    logic [N-1:0] one;
    one = 1;
    er  = (m_owner >= 0) ? (one << m_owner) : '0;
    check("src_ready", 32'(src_ready), 32'(er));
    check("busy", 32'(busy), 32'(m_owner >= 0));
    check("vga_plot", 32'(vga_plot), 32'(m_plot));
    check("vga_x", 32'(vga_x), 32'(m_x));
    check("vga_y", 32'(vga_y), 32'(m_y));
    check("vga_colour", 32'(vga_colour), 32'(m_c));
  endtask

  task automatic log_outputs();
    if (vga_plot === 1'b1 && plot_n < 4096) begin
      plot_log[plot_n] = {1'b0, vga_colour, vga_y, vga_x};
      plot_cyc[plot_n] = cyc;
      plot_n++;
    end
    if (busy === 1'b1 && !prev_busy && grant_n < 512) begin
      grant_log[grant_n] = -1;
      for (int i = 0; i < N; i++) if (src_ready[i]) grant_log[grant_n] = i;
      grant_n++;
    end
    prev_busy = (busy === 1'b1);
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) begin
      bit          v [N];
      bit          l [N];
      logic [23:0] w [N];
      int          acc, n_owner, n_last, n_idle;
      bit          n_plot;
      logic [9:0]  n_x, n_y;
      logic [2:0]  n_c;
      @(negedge clk);
      if (chk_en) compare();
      log_outputs();
      #1;
      for (int i = 0; i < N; i++) begin
        w[i] = mem[i][head[i] % 1024];
        v[i] = present[i] && (head[i] != tail[i]) && (int'($urandom_range(99)) >= bubble_pct);
        l[i] = w[i][23];
        src_valid[i]         = v[i];
        src_last[i]          = l[i];
        src_x[10*i +: 10]    = w[i][9:0];
        src_y[10*i +: 10]    = w[i][19:10];
        src_colour[3*i +: 3] = w[i][22:20];
      end
      acc = -1; n_owner = m_owner; n_last = m_last; n_idle = m_idle;
      n_plot = 1'b0; n_x = m_x; n_y = m_y; n_c = m_c;
      if (reset) begin
        n_owner = -1; n_last = N - 1; n_idle = 0; n_x = '0; n_y = '0; n_c = '0;
      end else if (m_owner < 0) begin
        n_idle = 0;
        for (int d = 1; d <= N; d++) begin
          if (v[(m_last + d) % N]) begin
            n_owner = (m_last + d) % N;
            break;
          end
        end
      end else if (v[m_owner]) begin
        acc    = m_owner;
        n_idle = 0;
        n_x    = w[m_owner][9:0];
        n_y    = w[m_owner][19:10];
        n_c    = w[m_owner][22:20];
        n_plot = (int'(n_x) < 160) && (int'(n_y) < 120);
        if (l[m_owner]) begin
          n_last  = m_owner;
          n_owner = -1;
        end
      end else begin
        n_idle = m_idle + 1;
        if (n_idle == TO) begin
          n_last = m_owner; n_owner = -1; n_idle = 0;
        end
      end
      @(posedge clk);
      #1;
      m_owner = n_owner; m_last = n_last; m_idle = n_idle;
      m_plot = n_plot; m_x = n_x; m_y = n_y; m_c = n_c;
      if (acc >= 0) head[acc]++;
      cyc++;
    end
  endtask

  initial begin
    reset = 1'b1; src_valid = '0; src_last = '0; src_x = '0; src_y = '0; src_colour = '0;
    bubble_pct = 0;
    for (int i = 0; i < N; i++) begin present[i] = 0; head[i] = 0; tail[i] = 0; end
    m_owner = -1; m_last = N - 1; m_idle = 0; m_plot = 0; m_x = '0; m_y = '0; m_c = '0;
    chk_en = 0; prev_busy = 0; cyc = 0; plot_n = 0; grant_n = 0;
    run(2);
    chk_en = 1;
    check("rst_ready", 32'(src_ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_plot", 32'(vga_plot), 32'd0);
    check("rst_xy", 32'({vga_x, vga_y}), 32'd0);

    // Single source: 20-pixel platform row
    reset = 1'b0;
    for (int k = 0; k < 20; k++) push(SRC_PLAT, 51 - k, 64, 4, k == 19);
    present[SRC_PLAT] = 1;
    pb = plot_n;
    run(24);
    check("t1_nplot", 32'(plot_n - pb), 32'd20);
    check("t1_first_x", 32'(plot_log[pb][9:0]), 32'd51);
    check("t1_last_x", 32'(plot_log[pb+19][9:0]), 32'd32);
    check("t1_y", 32'(plot_log[pb+19][19:10]), 32'd64);
    check("t1_colour", 32'(plot_log[pb][22:20]), 32'd4);
    check("t1_span", 32'(plot_cyc[pb+19] - plot_cyc[pb]), 32'd19);
    check("t1_busy_end", 32'(busy), 32'd0);

    // Contention: all three sources, src 0 has two bursts
    reset = 1'b1; run(1); reset = 1'b0;
    for (int s = 0; s < N; s++)
      for (int k = 0; k < 3; k++) push(s, 10*s + k, s + 1, s + 1, k == 2);
    for (int k = 0; k < 3; k++) push(SRC_PLAT, 30 + k, 1, 1, k == 2);
    for (int i = 0; i < N; i++) present[i] = 1;
    pb = plot_n; gb = grant_n;
    run(20);
    check("t2_grant0", 32'(grant_log[gb]), 32'd0);
    check("t2_grant1", 32'(grant_log[gb+1]), 32'd1);
    check("t2_grant2", 32'(grant_log[gb+2]), 32'd2);
    check("t2_grant3", 32'(grant_log[gb+3]), 32'd0);
    for (int j = 0; j < 12; j++)
      check("t2_burst_colour", 32'(plot_log[pb+j][22:20]), 32'((j < 9) ? (j / 3 + 1) : 1));

    // Clipping on the ball source
    push(SRC_BALL, 159, 10, 5, 0);
    push(SRC_BALL, 160, 10, 5, 0);
    push(SRC_BALL, 5, 120, 5, 0);
    push(SRC_BALL, 5, 119, 5, 1);
    pb = plot_n;
    run(8);
    check("t3_nplot", 32'(plot_n - pb), 32'd2);
    check("t3_p0", 32'(plot_log[pb][19:0]), 32'({10'd10, 10'd159}));
    check("t3_p1", 32'(plot_log[pb+1][19:0]), 32'({10'd119, 10'd5}));
    check("t3_busy_end", 32'(busy), 32'd0);

    // Watchdog: bricks stall mid-burst while platform waits
    reset = 1'b1; run(1); reset = 1'b0;
    present[SRC_PLAT] = 0;
    push(SRC_BRICK, 20, 20, 6, 0);
    push(SRC_BRICK, 21, 20, 6, 0);
    pb = plot_n;
    run(3);
    present[SRC_PLAT] = 1;
    for (int k = 0; k < 3; k++) push(SRC_PLAT, 70 + k, 30, 2, k == 2);
    run(63);
    check("t4_locked", 32'(src_ready), 32'b100);
    run(1);
    check("t4_release_ready", 32'(src_ready), 32'd0);
    check("t4_release_busy", 32'(busy), 32'd0);
    check("t4_nplot", 32'(plot_n - pb), 32'd2);
    run(1);
    check("t4_next_grant", 32'(src_ready), 32'b001);
    run(6);

    // Reset in the middle of a platform burst
    reset = 1'b1; run(1); reset = 1'b0;
    present[SRC_BALL] = 0;
    for (int k = 0; k < 10; k++) push(SRC_PLAT, 100 + k, 50, 2, k == 9);
    for (int k = 0; k < 3; k++) push(SRC_BALL, 1 + k, 2, 7, k == 2);
    run(5);
    reset = 1'b1;
    run(1);
    check("t5_plot", 32'(vga_plot), 32'd0);
    check("t5_ready", 32'(src_ready), 32'd0);
    check("t5_outputs", 32'({vga_colour, vga_x, vga_y}), 32'd0);
    reset = 1'b0;
    present[SRC_BALL] = 1;
    gb = grant_n;
    run(20);
    check("t5_first_grant", 32'(grant_log[gb]), 32'd0);
    check("t5_second_grant", 32'(grant_log[gb+1]), 32'd1);

    // Random traffic with bubbles, clipping, unterminated bursts and occasional reset
    bubble_pct = 25;
    for (int t = 0; t < 3000; t++) begin
      reset = ($urandom_range(0, 599) == 0);
      for (int s = 0; s < N; s++) begin
        if (head[s] == tail[s] && $urandom_range(0, 3) == 0) begin
          int len;
          bit open;
          len  = int'($urandom_range(1, 8));
          open = ($urandom_range(0, 9) == 0);
          for (int k = 0; k < len; k++)
            push(s, int'($urandom_range(0, 200)), int'($urandom_range(0, 150)),
                 int'($urandom_range(0, 7)), !open && (k == len - 1));
        end
      end
      run(1);
    end
    reset = 1'b0;
    bubble_pct = 0;
    run(200);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/pixel_arbiter.md
Name: pixel_arbiter

Overview:
- Downstream neighbour of the platform, ball and brick drawing FSMs.
- Merges their per-pixel streams (x, y, colour, write strobe) into the single pixel-write port of the VGA adapter.
- Round-robin, burst-locked arbitration: one object's pixel burst (e.g. a 20-pixel platform row) is never interleaved with another's.
- Clips off-screen pixels and releases a stalled source via a watchdog.

Parameters:
- N_SRC, 3, number of requesting draw sources (index 0 = platform, 1 = ball, 2 = bricks).
- SCREEN_W, 160, pixels with x >= SCREEN_W are dropped.
- SCREEN_H, 120, pixels with y >= SCREEN_H are dropped.
- TIMEOUT, 64, idle cycles in a locked burst before the grant is forcibly released.

Ports:
- clk  in  1  system clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- src_valid  in  N_SRC  per-source pixel-valid strobe.
- src_last  in  N_SRC  marks the final pixel of a source's burst.
- src_x  in  10*N_SRC  packed x coordinates; source i at bits [10i+9:10i].
- src_y  in  10*N_SRC  packed y coordinates, same packing.
- src_colour  in  3*N_SRC  packed colours; source i at bits [3i+2:3i].
- src_ready  out  N_SRC  one-hot grant; source i advances only on src_valid[i] & src_ready[i].
- vga_x  out  10  registered pixel x.
- vga_y  out  10  registered pixel y.
- vga_colour  out  3  registered pixel colour.
- vga_plot  out  1  one-cycle write strobe to the VGA adapter.
- busy  out  1  high while in BURST.

Behaviour:
- Reset (synchronous, active-high):
  - state = IDLE, src_ready = 0, vga_plot = 0, vga_x = vga_y = 0, vga_colour = 0, busy = 0.
  - last_served = N_SRC-1, so source 0 has first priority.
  - Watchdog counter cleared.
  - Reset mid-burst abandons the burst; no pixel is plotted in the cycle after reset.
- State IDLE:
  - src_ready = 0.
  - If any src_valid is set, select the first valid index scanning (last_served+1) mod N_SRC upward with wrap.
  - Register it as grant and go to BURST next cycle.
  - No valid sources: remain in IDLE.
- State BURST:
  - src_ready[grant] = 1 (combinational from grant register); all other bits 0. busy = 1.
  - Accept = src_valid[grant] & src_ready[grant].
  - On accept: latch that source's x/y/colour into the vga_* registers.
  - vga_plot = 1 on the following cycle, only if x < SCREEN_W and y < SCREEN_H (compare full 10 bits, unsigned).
  - Latency: one cycle from accept to plot. Throughput: one pixel per cycle.
  - Accept with src_last: last_served = grant; go to IDLE (one dead cycle between bursts).
  - Non-granted sources' valid/last are ignored and must hold their pixel until granted.
  - src_last on a clipped pixel still ends the burst.
- Watchdog:
  - Counter clears on every accept; increments each BURST cycle without an accept.
  - On reaching TIMEOUT-1: return to IDLE, last_served = grant, no plot.
- Simultaneous events:
  - All sources valid in IDLE: round-robin choice only; no fixed priority beyond the rotation.
  - Accept with last and watchdog expiry in the same cycle: the accept wins (pixel plotted, normal release).
- vga_plot is low in every cycle that does not directly follow an in-bounds accept.

Decomposition:
- Shared package/macro header holds:
  - screen constants SCREEN_W / SCREEN_H, alongside the existing GRID/BRICK/PLAT constants;
  - source index constants SRC_PLAT = 0, SRC_BALL = 1, SRC_BRICK = 2;
  - state encodings IDLE = 1'b0, BURST = 1'b1.
- One sub-module is natural: rr_picker. It is combinational: given the valid vector and last_served, it returns the next grant index and an any_valid flag.
- Everything else (FSM, output registers, clipping, watchdog) lives in pixel_arbiter.

Test Plan:
- Single source: src 0 bursts 20 pixels x = 51..32, y = 64, colour 3'b100, last on the 20th.
  - Expect 20 consecutive vga_plot pulses, each one cycle after its accept, with matching coordinates.
  - busy then drops; one IDLE cycle follows.
- Contention: sources 0, 1 and 2 all valid with 3-pixel bursts, starting right after reset.
  - Expect grant order 0, 1, 2, then 0 again.
  - No interleaving of pixels within a burst.
- Clipping: src 1 sends (159, 10), (160, 10), (5, 120), (5, 119).
  - Expect plots only for (159, 10) and (5, 119); the 4th pixel's last ends the burst.
- Stall and watchdog: src 2 is granted, sends 2 pixels, then drops valid for 64 cycles.
  - Expect release at cycle 64 with no spurious plot.
  - A waiting src 0 is granted next.
- Reset mid-burst: assert reset on the 5th pixel of a src 0 burst.
  - Next cycle: vga_plot = 0, src_ready = 0, outputs zero.
  - After release, src 0 wins first under contention with src 1.
